bus_dma_master: RTL
===================

Name: bus_dma_master

Overview:
- Bus initiator (master end) for the single-master 64-bit shared bus, which has a 16-bit address and two slaves.
- On a start pulse, copies a block of 64-bit words from a source address range to a destination address range, one word at a time.
- Each word is a bus read followed by a bus write.
- Drives the master-side ports of the bus interconnect (m_req/m_wr/m_addr/m_dout, with m_grant/m_din returned) and reports busy/done to a local controller.

Parameters:
- LEN_W, 8, width of the transfer-length input (max LEN_W'hFF words per transfer)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE
- src_addr  input  16  first source word address; sampled with start
- dst_addr  input  16  first destination word address; sampled with start
- length  input  LEN_W  number of words to copy; sampled with start
- m_grant  input  1  bus grant; request is held until it is high
- m_din  input  64  read data from bus; valid the cycle after a granted read
- m_req  output  1  bus request
- m_wr  output  1  1 = write, 0 = read; meaningful only while m_req=1
- m_addr  output  16  bus address
- m_dout  output  64  write data
- busy  output  1  high from the cycle after an accepted start until DONE is left
- done  output  1  one-cycle pulse at transfer completion

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low (reset_n sampled on the rising edge of clk).
  - Reset values: state=IDLE, m_req=0, m_wr=0, m_addr=0, m_dout=0, busy=0, done=0; internal src/dst pointers, counter and data register = 0.
- Outputs are registered, except m_req/m_wr, which are decoded from state. All outputs change only on clk edges.
- States:
  - IDLE: m_req=0, busy=0.
    - start=1 and length!=0: latch src/dst/length, go to RD_REQ.
    - start=1 and length=0: go to DONE (no bus activity).
  - RD_REQ: m_req=1, m_wr=0, m_addr=src_ptr.
    - m_grant=1: go to RD_WAIT.
    - m_grant=0: stay, outputs unchanged.
  - RD_WAIT: m_req=0.
    - Capture m_din into the data register at the end of this cycle (one-cycle read latency: the bus registers the slave select on the request edge).
    - Go to WR_REQ.
  - WR_REQ: m_req=1, m_wr=1, m_addr=dst_ptr, m_dout=data register.
    - m_grant=0: stay, outputs unchanged.
    - m_grant=1: src_ptr+=1, dst_ptr+=1, count-=1.
      - If count was 1, go to DONE; otherwise go to RD_REQ.
  - DONE: done=1 for exactly one cycle, m_req=0; go to IDLE. busy drops entering IDLE.
- Throughput with constant grant: 3 cycles per word. Total from start edge to done pulse = 3*length+1 cycles.
- Address arithmetic: 16-bit modulo, so 16'hFFFF+1 wraps to 16'h0000 with no error. Source and destination ranges may overlap; the copy proceeds strictly in ascending order.
- start while not in IDLE: ignored; inputs are not re-sampled.
- start in the same cycle as DONE: ignored. A new start is accepted only in IDLE.
- reset_n=0 at any point, including while m_req=1: next edge forces IDLE and all reset values. The partial transfer is abandoned with no done pulse.
- m_grant low for N cycles in a request state: request held stable for N extra cycles; data and pointers unchanged.
- m_din is ignored in every state except RD_WAIT.

Test Plan:
1. Reset, then start with src=16'h0010, dst=16'h0100, length=1, slave word at 0x0010 = 64'hDEADBEEF_01234567, grant tied high -> in order: RD_REQ (addr 0x0010, wr=0), WR_REQ (addr 0x0100, wr=1, dout=64'hDEADBEEF_01234567); done pulses 4 cycles after start; busy returns to 0.
2. length=4, src=0x0000, dst=0x8000 (other slave), words 1,2,3,4 -> writes to 0x8000..0x8003 with data 1..4 in order; done at cycle 13; m_req never high in RD_WAIT.
3. length=0 -> no m_req at all; done pulses the cycle after start; busy high for 1 cycle.
4. src=16'hFFFF, length=2 -> second read address 16'h0000; dst increments similarly wrap-free.
5. m_grant held low 3 cycles during first RD_REQ and 2 during WR_REQ -> m_addr/m_wr/m_dout stable while waiting; done delayed by exactly 5 cycles versus scenario 1.
6. length=3, reset_n=0 asserted during second WR_REQ -> next edge all outputs 0, no done pulse; later start with length=1 completes normally; start pulses issued mid-transfer are ignored.

Source files
------------

// File: rtl/bus_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_dma_master
// Brief    : Block copy engine; moves 64-bit words from a source range to a
//            destination range as a read/write pair per word on the shared bus.
// Revision : 1.0 - initial release
// ============================================================================
module bus_dma_master #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [15:0]      src_addr,
   input  logic [15:0]      dst_addr,
   input  logic [LEN_W-1:0] length,
   input  logic             m_grant,
   input  logic [63:0]      m_din,
   output logic             m_req,
   output logic             m_wr,
   output logic [15:0]      m_addr,
   output logic [63:0]      m_dout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [15:0]      c_addr_inc  = 16'd1;
   localparam logic [LEN_W-1:0] c_count_one = LEN_W'(1);
   localparam logic [LEN_W-1:0] c_count_zero = '0;

   state_t           r_state;
   state_t           w_next_state;
   logic [15:0]      r_src_ptr;
   logic [15:0]      r_dst_ptr;
   logic [15:0]      r_addr;
   logic [LEN_W-1:0] r_count;
   logic [63:0]      r_data;
   logic             r_busy;
   logic             r_done;
   logic             w_last;
   logic             w_accept;

   assign w_last   = (r_count == c_count_one);
   assign w_accept = (r_state == ST_IDLE) && start && (length != c_count_zero);

   // ------------------------------------------------------------------------
   // Next-state and request decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      m_req        = 1'b0;
      m_wr         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = (length != c_count_zero) ? ST_RD_REQ : ST_DONE;
            end
         end
         ST_RD_REQ: begin
            m_req = 1'b1;
            if (m_grant) begin
               w_next_state = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            w_next_state = ST_WR_REQ;
         end
         ST_WR_REQ: begin
            m_req = 1'b1;
            m_wr  = 1'b1;
            if (m_grant) begin
               w_next_state = w_last ? ST_DONE : ST_RD_REQ;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != ST_IDLE);
         r_done  <= (w_next_state == ST_DONE);
      end
   end

   // ------------------------------------------------------------------------
   // Pointers, word counter, data register and the registered bus address
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_src_ptr <= 16'h0000;
         r_dst_ptr <= 16'h0000;
         r_addr    <= 16'h0000;
         r_count   <= c_count_zero;
         r_data    <= 64'h0;
      end else begin
         if (w_accept) begin
            r_src_ptr <= src_addr;
            r_dst_ptr <= dst_addr;
            r_count   <= length;
            r_addr    <= src_addr;
         end
         // The bus returns read data one cycle after the granted request.
         if (r_state == ST_RD_WAIT) begin
            r_data <= m_din;
            r_addr <= r_dst_ptr;
         end
         if ((r_state == ST_WR_REQ) && m_grant) begin
            r_src_ptr <= r_src_ptr + c_addr_inc;
            r_dst_ptr <= r_dst_ptr + c_addr_inc;
            r_count   <= r_count - c_count_one;
            r_addr    <= r_src_ptr + c_addr_inc;
         end
      end
   end

   assign m_addr = r_addr;
   assign m_dout = r_data;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule
`default_nettype wire
